// File: rtl/mux_pattern_sequencer_pkg.sv
// Shared definitions for the 2:1 mux pattern sequencer: FSM encoding and
// the reference rule for the expected mux output.
package mux_pattern_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   localparam int HOLD_W = 8;
   localparam int IDX_W  = 3;

   // sel_picks_b=1: c = selector ? b : a ; sel_picks_b=0: c = selector ? a : b
   function automatic logic expected_c(input logic a,
                                       input logic b,
                                       input logic selector,
                                       input logic sel_picks_b);
      logic w_pick;
      w_pick = sel_picks_b ? selector : ~selector;
      return w_pick ? b : a;
   endfunction

endpackage

// File: rtl/mux_pattern_sequencer.sv
// Walks {a,b,selector} through patterns 0..NUM_PATTERNS-1, holds each for
// HOLD_CYCLES clocks, checks the fed-back mux output and counts mismatches.
module mux_pattern_sequencer
   import mux_pattern_sequencer_pkg::*;
#(
   parameter int NUM_PATTERNS = 8,
   parameter int HOLD_CYCLES  = 10,
   parameter int SEL_PICKS_B  = 1,
   parameter int ERR_W        = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             c_in,
   output logic             a,
   output logic             b,
   output logic             selector,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_count,
   output logic [2:0]       pattern_idx,
   output logic [1:0]       dbg_state
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PATTERNS - 1);

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [HOLD_W-1:0]   r_hold;
   logic [ERR_W-1:0]    r_err;
   logic                r_done;

   state_t              w_state_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [ERR_W-1:0]    w_err_nxt;
   logic                w_done_nxt;
   logic                w_exp;

   assign w_exp = expected_c(r_idx[2], r_idx[1], r_idx[0], SEL_PICKS_B != 0);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_hold_nxt  = r_hold;
      w_err_nxt   = r_err;
      w_done_nxt  = 1'b0;
      // abort overrides every transition but leaves the partial error count
      if (abort) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = '0;
         w_hold_nxt  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nxt = ST_DRIVE;
                  w_idx_nxt   = '0;
                  w_hold_nxt  = '0;
                  w_err_nxt   = '0;
               end
            end
            ST_DRIVE: begin
               w_hold_nxt = r_hold + 8'd1;
               if (r_hold == HOLD_LAST) begin
                  w_state_nxt = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if ((c_in != w_exp) && (r_err != '1)) begin
                  w_err_nxt = r_err + ERR_W'(1);
               end
               w_hold_nxt = '0;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_idx_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_DRIVE;
                  w_idx_nxt   = r_idx + 3'd1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_hold_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_hold  <= '0;
         r_err   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_hold  <= w_hold_nxt;
         r_err   <= w_err_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign a           = r_idx[2];
   assign b           = r_idx[1];
   assign selector    = r_idx[0];
   assign pattern_idx = r_idx;
   assign busy        = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
   assign done        = r_done;
   assign err_count   = r_err;
   assign dbg_state   = r_state;

endmodule
